// File: rtl/vram_arbiter_if.sv
// ---------------------------------------------------------------------------
// vram_arbiter_if
// Bundles every request/response and RAM-side signal of the VRAM arbiter.
//   Video fetch : vid_req, vid_addr -> vid_data, vid_valid
//   CPU access  : cpu_req, cpu_we, cpu_addr, cpu_din, cpu_rd_bank, cpu_wr_bank
//                 -> cpu_dout, cpu_ack, cpu_wait_n
//   Fill engine : clr_start, clr_mask, clr_value -> clr_busy, clr_done
//   RAM side    : mem_ce, mem_we, mem_addr, mem_din -> (from RAM) mem_q
// The slave modport is the arbiter; master is its environment (VDP, Z80
// decode and the RAM planes).
// ---------------------------------------------------------------------------
interface vram_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int PLANES = 6,
  parameter int DW     = 8
);
  logic                   vid_req;
  logic [ADDR_W-1:0]      vid_addr;
  logic [PLANES*DW-1:0]   vid_data;
  logic                   vid_valid;

  logic                   cpu_req;
  logic                   cpu_we;
  logic [ADDR_W-1:0]      cpu_addr;
  logic [DW-1:0]          cpu_din;
  logic [7:0]             cpu_rd_bank;
  logic [7:0]             cpu_wr_bank;
  logic [DW-1:0]          cpu_dout;
  logic                   cpu_ack;
  logic                   cpu_wait_n;

  logic                   clr_start;
  logic [PLANES-1:0]      clr_mask;
  logic [DW-1:0]          clr_value;
  logic                   clr_busy;
  logic                   clr_done;

  logic [PLANES-1:0]      mem_ce;
  logic                   mem_we;
  logic [ADDR_W-1:0]      mem_addr;
  logic [DW-1:0]          mem_din;
  logic [PLANES*DW-1:0]   mem_q;

  modport slave (
    input  vid_req, vid_addr,
    output vid_data, vid_valid,
    input  cpu_req, cpu_we, cpu_addr, cpu_din, cpu_rd_bank, cpu_wr_bank,
    output cpu_dout, cpu_ack, cpu_wait_n,
    input  clr_start, clr_mask, clr_value,
    output clr_busy, clr_done,
    output mem_ce, mem_we, mem_addr, mem_din,
    input  mem_q
  );

  modport master (
    output vid_req, vid_addr,
    input  vid_data, vid_valid,
    output cpu_req, cpu_we, cpu_addr, cpu_din, cpu_rd_bank, cpu_wr_bank,
    input  cpu_dout, cpu_ack, cpu_wait_n,
    output clr_start, clr_mask, clr_value,
    input  clr_busy, clr_done,
    input  mem_ce, mem_we, mem_addr, mem_din,
    output mem_q
  );
endinterface

// File: rtl/vram_arbiter.sv
// ---------------------------------------------------------------------------
// vram_arbiter
// Shares the single-port video RAM (PLANES planes of 2**ADDR_W x DW) between
// the VDP fetch path, the Z80 CPU and a built-in clear/fill engine, with
// fixed priority video > CPU > fill. One RAM operation is issued per clock.
//
// Ports:
//   clk      : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : vram_arbiter_if.slave (video, CPU, fill and RAM-side signals)
//
// Pipeline (E0 = issuing edge):
//   E0 : arbitration, mem_* registered              (stage p1)
//   E1 : RAM samples mem_*, op tag advances         (stage p2)
//   E2 : mem_q captured into vid_data / cpu_dout, vid_valid / cpu_ack pulse
// Video latency is therefore fixed at two clocks after the sampling edge and
// is never stretched, since video always wins arbitration.
// ---------------------------------------------------------------------------
module vram_arbiter #(
  parameter int ADDR_W = 13,
  parameter int PLANES = 6,
  parameter int DW     = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  vram_arbiter_if.slave       bus
);

  localparam logic [PLANES-1:0] ALL_PLANES = '1;
  localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;

  // F1 read-bank value -> one-hot plane select; values outside 1..PLANES
  // select nothing, which makes the read return zero.
  function automatic logic [PLANES-1:0] rd_onehot(input logic [7:0] bank);
    rd_onehot = '0;
    for (int i = 0; i < PLANES; i++) begin
      if (bank == 8'(i + 1)) rd_onehot[i] = 1'b1;
    end
  endfunction

  function automatic logic [DW-1:0] pick_plane(input logic [PLANES*DW-1:0] q,
                                               input logic [PLANES-1:0]    sel);
    pick_plane = '0;
    for (int i = 0; i < PLANES; i++) begin
      if (sel[i]) pick_plane = q[i*DW +: DW];
    end
  endfunction

  // Control / output registers
  logic                 r_vid_vld_p1, r_vid_vld_p2;
  logic                 r_cpu_vld_p1, r_cpu_vld_p2;
  logic [PLANES-1:0]    r_mem_ce;
  logic                 r_mem_we;
  logic [ADDR_W-1:0]    r_mem_addr;
  logic [DW-1:0]        r_mem_din;
  logic [PLANES*DW-1:0] r_vid_data;
  logic                 r_vid_valid;
  logic [DW-1:0]        r_cpu_dout;
  logic                 r_cpu_ack;
  logic                 r_clr_busy;
  logic                 r_clr_done;
  logic [ADDR_W-1:0]    r_clr_cnt;

  // Data-only registers (meaningful only alongside a valid tag)
  logic [PLANES-1:0]    r_rd_sel_p1, r_rd_sel_p2;
  logic [PLANES-1:0]    r_clr_mask;
  logic [DW-1:0]        r_clr_value;

  logic                 w_cpu_busy;
  logic                 w_vid_issue;
  logic                 w_cpu_issue;
  logic                 w_fill_issue;
  logic                 w_fill_start;
  logic                 w_unused_wr_bank;

  // F2 bits above the plane count carry no meaning.
  assign w_unused_wr_bank = ^bus.cpu_wr_bank[7:PLANES];

  // --- stage p0: arbitration ---
  // The CPU request level stays high through its own ack cycle, so the ack
  // register also blocks re-issue; the next request can go at the edge after.
  assign w_cpu_busy   = r_cpu_vld_p1 | r_cpu_vld_p2 | r_cpu_ack;
  assign w_vid_issue  = bus.vid_req;
  assign w_cpu_issue  = !bus.vid_req && bus.cpu_req && !w_cpu_busy;
  assign w_fill_issue = !bus.vid_req && !w_cpu_issue && r_clr_busy;
  assign w_fill_start = !r_clr_busy && bus.clr_start;

  // --- stage p1: drive the RAM ---
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vid_vld_p1 <= 1'b0;
      r_cpu_vld_p1 <= 1'b0;
      r_mem_ce     <= '0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_din    <= '0;
    end else begin
      r_vid_vld_p1 <= w_vid_issue;
      r_cpu_vld_p1 <= w_cpu_issue;
      if (w_vid_issue) begin
        r_mem_ce   <= ALL_PLANES;
        r_mem_we   <= 1'b0;
        r_mem_addr <= bus.vid_addr;
      end else if (w_cpu_issue) begin
        r_mem_addr <= bus.cpu_addr;
        if (bus.cpu_we) begin
          // A zero write mask simply enables no plane; the ack still follows.
          r_mem_ce  <= bus.cpu_wr_bank[PLANES-1:0];
          r_mem_we  <= 1'b1;
          r_mem_din <= bus.cpu_din;
        end else begin
          r_mem_ce  <= rd_onehot(bus.cpu_rd_bank);
          r_mem_we  <= 1'b0;
        end
      end else if (w_fill_issue) begin
        r_mem_ce   <= r_clr_mask;
        r_mem_we   <= 1'b1;
        r_mem_addr <= r_clr_cnt;
        r_mem_din  <= r_clr_value;
      end else begin
        r_mem_ce   <= '0;
        r_mem_we   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    r_rd_sel_p1 <= (w_cpu_issue && !bus.cpu_we) ? rd_onehot(bus.cpu_rd_bank) : '0;
    r_rd_sel_p2 <= r_rd_sel_p1;
    if (w_fill_start) begin
      r_clr_mask  <= bus.clr_mask;
      r_clr_value <= bus.clr_value;
    end
  end

  // --- stage p2: RAM access in progress; p3: capture mem_q ---
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vid_vld_p2 <= 1'b0;
      r_cpu_vld_p2 <= 1'b0;
      r_vid_valid  <= 1'b0;
      r_vid_data   <= '0;
      r_cpu_ack    <= 1'b0;
      r_cpu_dout   <= '0;
    end else begin
      r_vid_vld_p2 <= r_vid_vld_p1;
      r_cpu_vld_p2 <= r_cpu_vld_p1;
      r_vid_valid  <= r_vid_vld_p2;
      r_cpu_ack    <= r_cpu_vld_p2;
      if (r_vid_vld_p2) r_vid_data <= bus.mem_q;
      if (r_cpu_vld_p2) r_cpu_dout <= pick_plane(bus.mem_q, r_rd_sel_p2);
    end
  end

  // Fill engine: sweeps every address once; stops without wrapping after
  // issuing the last one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clr_busy <= 1'b0;
      r_clr_done <= 1'b0;
      r_clr_cnt  <= '0;
    end else begin
      r_clr_done <= 1'b0;
      if (w_fill_start) begin
        r_clr_busy <= 1'b1;
        r_clr_cnt  <= '0;
      end else if (w_fill_issue) begin
        if (r_clr_cnt == LAST_ADDR) begin
          r_clr_busy <= 1'b0;
          r_clr_done <= 1'b1;
        end else begin
          r_clr_cnt  <= r_clr_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.mem_ce     = r_mem_ce;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_din    = r_mem_din;
  assign bus.vid_data   = r_vid_data;
  assign bus.vid_valid  = r_vid_valid;
  assign bus.cpu_dout   = r_cpu_dout;
  assign bus.cpu_ack    = r_cpu_ack;
  assign bus.cpu_wait_n = !bus.cpu_req || r_cpu_ack;
  assign bus.clr_busy   = r_clr_busy;
  assign bus.clr_done   = r_clr_done;

endmodule

// File: tb/tb_vram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vram_arbiter
// Directed bench for vram_arbiter: a vector table of video/CPU operations
// plus hand-written sequences for priority, fill, fill/CPU interleave and
// reset in the middle of an operation. A behavioural six-plane RAM model
// answers the DUT's memory port.
// ---------------------------------------------------------------------------
module tb_vram_arbiter;

  localparam int K_VID = 0;
  localparam int K_WR  = 1;
  localparam int K_RD  = 2;

  typedef struct {
    int          kind;
    logic [12:0] addr;
    logic [7:0]  din;
    logic [7:0]  wrb;
    logic [7:0]  rdb;
    logic [47:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  int   n_vec = 0;
  int   n_mis = 0;

  vram_arbiter_if bus();

  vram_arbiter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Six synchronous 8K x 8 planes, shared write data, per-plane enable.
  logic [7:0] ram [6][8192] = '{default: 8'h00};

  always @(posedge clk) begin
    for (int p = 0; p < 6; p++) begin
      if (bus.mem_ce[p]) begin
        if (bus.mem_we) ram[p][bus.mem_addr] <= bus.mem_din;
        else            bus.mem_q[p*8 +: 8] <= ram[p][bus.mem_addr];
      end
    end
  end

  // Counts RAM write cycles and fill-done pulses while enabled.
  logic mon_en  = 1'b0;
  logic mon_clr = 1'b0;
  int   we_cnt   = 0;
  int   done_cnt = 0;

  always @(posedge clk) begin
    if (mon_clr) begin
      we_cnt   <= 0;
      done_cnt <= 0;
    end else if (mon_en) begin
      if (bus.mem_we)   we_cnt   <= we_cnt + 1;
      if (bus.clr_done) done_cnt <= done_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic vid_op(input string name, input logic [12:0] addr, input logic [47:0] exp);
    int   n;
    logic got;
    logic [47:0] data;
    @(negedge clk);
    bus.vid_req  = 1'b1;
    bus.vid_addr = addr;
    n = 0; got = 1'b0; data = '0;
    while (!got && n < 20) begin
      @(negedge clk);
      bus.vid_req = 1'b0;
      n++;
      if (bus.vid_valid) begin
        got  = 1'b1;
        data = bus.vid_data;
      end
    end
    check({name, " vid_lat"}, got ? 64'(n - 1) : 64'd99, 64'd2);
    check({name, " vid_data"}, 64'(data), 64'(exp));
  endtask

  task automatic cpu_op(input string name, input logic we, input logic [12:0] addr,
                        input logic [7:0] din, input logic [7:0] wrb, input logic [7:0] rdb,
                        input logic [7:0] exp);
    int   n;
    logic got;
    logic wn_ok;
    logic [7:0] dout;
    @(negedge clk);
    bus.cpu_req     = 1'b1;
    bus.cpu_we      = we;
    bus.cpu_addr    = addr;
    bus.cpu_din     = din;
    bus.cpu_wr_bank = wrb;
    bus.cpu_rd_bank = rdb;
    n = 0; got = 1'b0; wn_ok = 1'b1; dout = '0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (bus.cpu_ack) begin
        got  = 1'b1;
        dout = bus.cpu_dout;
        if (bus.cpu_wait_n !== 1'b1) wn_ok = 1'b0;
      end else if (bus.cpu_wait_n !== 1'b0) begin
        wn_ok = 1'b0;
      end
    end
    bus.cpu_req = 1'b0;
    check({name, " cpu_lat"}, got ? 64'(n - 1) : 64'd99, 64'd2);
    check({name, " wait_n"}, 64'(wn_ok), 64'd1);
    if (!we) check({name, " cpu_dout"}, 64'(dout), 64'(exp));
  endtask

  initial begin
    vec_t tbl[16];
    logic [20:0] vv, ak, wn, exp_vv, exp_ak, exp_wn;
    int   bad, busy_cnt, dn_cnt;
    logic [7:0] pr_dout;
    logic ack_seen;

    tbl[0]  = '{K_WR,  13'h0010, 8'h5A, 8'h37, 8'h00, 48'h0};
    tbl[1]  = '{K_WR,  13'h0010, 8'hA5, 8'h08, 8'h00, 48'h0};
    tbl[2]  = '{K_VID, 13'h0010, 8'h00, 8'h00, 8'h00, 48'h5A5AA55A5A5A};
    tbl[3]  = '{K_WR,  13'h1234, 8'h3C, 8'h05, 8'h00, 48'h0};
    tbl[4]  = '{K_RD,  13'h1234, 8'h00, 8'h00, 8'h03, 48'h3C};
    tbl[5]  = '{K_RD,  13'h1234, 8'h00, 8'h00, 8'h02, 48'h00};
    tbl[6]  = '{K_RD,  13'h1234, 8'h00, 8'h00, 8'h01, 48'h3C};
    tbl[7]  = '{K_RD,  13'h1234, 8'h00, 8'h00, 8'h07, 48'h00};
    tbl[8]  = '{K_RD,  13'h1234, 8'h00, 8'h00, 8'h00, 48'h00};
    tbl[9]  = '{K_VID, 13'h1234, 8'h00, 8'h00, 8'h00, 48'h00000000003C_003C & 48'h00000000FFFF | 48'h00000000003C_0000 >> 16 << 16};
    tbl[9].exp = 48'h00_00_00_3C_00_3C;
    tbl[10] = '{K_WR,  13'h1FFF, 8'h5A, 8'hFF, 8'h00, 48'h0};
    tbl[11] = '{K_VID, 13'h1FFF, 8'h00, 8'h00, 8'h00, 48'h5A5A5A5A5A5A};
    tbl[12] = '{K_WR,  13'h0001, 8'h77, 8'h00, 8'h00, 48'h0};
    tbl[13] = '{K_VID, 13'h0001, 8'h00, 8'h00, 8'h00, 48'h000000000000};
    tbl[14] = '{K_RD,  13'h1FFF, 8'h00, 8'h00, 8'h06, 48'h5A};
    tbl[15] = '{K_RD,  13'h0010, 8'h00, 8'h00, 8'h04, 48'hA5};

    reset_n         = 1'b0;
    bus.vid_req     = 1'b0;
    bus.vid_addr    = '0;
    bus.cpu_req     = 1'b0;
    bus.cpu_we      = 1'b0;
    bus.cpu_addr    = '0;
    bus.cpu_din     = '0;
    bus.cpu_rd_bank = '0;
    bus.cpu_wr_bank = '0;
    bus.clr_start   = 1'b0;
    bus.clr_mask    = '0;
    bus.clr_value   = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst vid", 64'({bus.vid_data, bus.vid_valid}), 64'd0);
    check("rst ctl", 64'({bus.cpu_dout, bus.cpu_ack, bus.clr_busy, bus.clr_done,
                          bus.mem_ce, bus.mem_we, bus.mem_addr, bus.mem_din}), 64'd0);
    check("rst wait_n idle", 64'(bus.cpu_wait_n), 64'd1);
    bus.cpu_req = 1'b1;
    #1 check("rst wait_n req", 64'(bus.cpu_wait_n), 64'd0);
    bus.cpu_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Vector table
    for (int i = 0; i < 16; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      case (tbl[i].kind)
        K_VID:   vid_op(nm, tbl[i].addr, tbl[i].exp);
        K_WR:    cpu_op(nm, 1'b1, tbl[i].addr, tbl[i].din, tbl[i].wrb, 8'h00, 8'h00);
        default: cpu_op(nm, 1'b0, tbl[i].addr, 8'h00, 8'h00, tbl[i].rdb, tbl[i].exp[7:0]);
      endcase
    end

    // Priority: video every cycle for 10 cycles with a CPU read held.
    // Sample t is taken at the falling edge before the inputs of cycle t.
    bad = 0; pr_dout = '0;
    for (int t = 0; t < 21; t++) begin
      @(negedge clk);
      vv[t] = bus.vid_valid;
      ak[t] = bus.cpu_ack;
      wn[t] = bus.cpu_wait_n;
      exp_vv[t] = (t >= 3 && t <= 12);
      exp_ak[t] = (t == 13);
      exp_wn[t] = !(t >= 1 && t <= 12);
      if (bus.vid_valid && bus.vid_data !== 48'h5A5AA55A5A5A) bad++;
      if (bus.cpu_ack) begin
        pr_dout = bus.cpu_dout;
        bus.cpu_req = 1'b0;
      end
      if (t == 0) begin
        bus.cpu_req     = 1'b1;
        bus.cpu_we      = 1'b0;
        bus.cpu_addr    = 13'h1234;
        bus.cpu_rd_bank = 8'h03;
      end
      bus.vid_req  = (t < 10);
      bus.vid_addr = 13'h0010;
    end
    check("prio vid_valid", 64'(vv), 64'(exp_vv));
    check("prio cpu_ack", 64'(ak), 64'(exp_ak));
    check("prio wait_n", 64'(wn), 64'(exp_wn));
    check("prio vid_data", 64'(bad), 64'd0);
    check("prio cpu_dout", 64'(pr_dout), 64'h3C);

    // Full fill with a second start mid-fill that must be ignored.
    @(negedge clk);
    bus.clr_start = 1'b1;
    bus.clr_mask  = 6'h3F;
    bus.clr_value = 8'hFF;
    @(negedge clk);
    bus.clr_start = 1'b0;
    busy_cnt = 0; dn_cnt = 0;
    for (int c = 0; c < 9000; c++) begin
      if (bus.clr_busy) busy_cnt++;
      if (bus.clr_done) dn_cnt++;
      bus.clr_start = (c == 100);
      bus.clr_mask  = (c == 100) ? 6'h01 : 6'h3F;
      bus.clr_value = (c == 100) ? 8'h00 : 8'hFF;
      @(negedge clk);
    end
    bad = 0;
    for (int p = 0; p < 6; p++)
      for (int a = 0; a < 8192; a++)
        if (ram[p][a] !== 8'hFF) bad++;
    check("fill busy cycles", 64'(busy_cnt), 64'd8192);
    check("fill done pulses", 64'(dn_cnt), 64'd1);
    check("fill contents", 64'(bad), 64'd0);

    // Fill with zero while the CPU writes 0x11 behind the sweep.
    mon_clr = 1'b1;
    @(negedge clk);
    mon_clr = 1'b0;
    mon_en  = 1'b1;
    bus.clr_start = 1'b1;
    bus.clr_mask  = 6'h3F;
    bus.clr_value = 8'h00;
    @(negedge clk);
    bus.clr_start = 1'b0;
    repeat (50) @(negedge clk);
    cpu_op("ilv wr", 1'b1, 13'h0000, 8'h11, 8'h3F, 8'h00, 8'h00);
    busy_cnt = 0;
    while (bus.clr_busy && busy_cnt < 9000) begin
      @(negedge clk);
      busy_cnt++;
    end
    check("ilv finished", 64'(bus.clr_busy), 64'd0);
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    bad = 0;
    for (int p = 0; p < 6; p++) begin
      if (ram[p][0] !== 8'h11) bad++;
      if (ram[p][1] !== 8'h00) bad++;
      if (ram[p][8191] !== 8'h00) bad++;
    end
    check("ilv writes", 64'(we_cnt), 64'd8193);
    check("ilv done", 64'(done_cnt), 64'd1);
    check("ilv contents", 64'(bad), 64'd0);

    // Reset one cycle after a CPU read issues, with a fill pending.
    @(negedge clk);
    bus.clr_start = 1'b1;
    bus.clr_mask  = 6'h3F;
    bus.clr_value = 8'h22;
    @(negedge clk);
    bus.clr_start   = 1'b0;
    bus.cpu_req     = 1'b1;
    bus.cpu_we      = 1'b0;
    bus.cpu_addr    = 13'h1234;
    bus.cpu_rd_bank = 8'h03;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid rst vid", 64'({bus.vid_data, bus.vid_valid}), 64'd0);
    check("mid rst ctl", 64'({bus.cpu_dout, bus.cpu_ack, bus.clr_busy, bus.clr_done,
                              bus.mem_ce, bus.mem_we, bus.mem_addr, bus.mem_din}), 64'd0);
    check("mid rst wait_n", 64'(bus.cpu_wait_n), 64'd0);
    ack_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.cpu_ack) ack_seen = 1'b1;
    end
    bus.cpu_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.cpu_ack) ack_seen = 1'b1;
      if (bus.clr_busy) bad++;
    end
    check("mid rst no ack", 64'(ack_seen), 64'd0);
    check("mid rst fill idle", 64'(bad), 64'd0);
    cpu_op("post rst rd", 1'b0, 13'h0000, 8'h00, 8'h00, 8'h01, 8'h11);
    vid_op("post rst", 13'h0000, 48'h111111111111);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single-port video RAM (six 8K x 8 planes: fg1-3, bg1-3) between three requesters with fixed priority: VDP fetch, then CPU read/write, then a built-in clear/fill engine.
- Sits between the Z80 memory decode at EC00-FFFF (with the F1 read-bank and F2 write-bank registers) and the VDP fetch path.
- Gives the VDP fixed-latency reads and stalls the CPU through a wait handshake.

Parameters:
- ADDR_W, 13, VRAM word address width (8192 locations per plane)
- PLANES, 6, number of VRAM planes
- DW, 8, data width per plane

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- vid_req  in  1  VDP fetch request, single-cycle pulse
- vid_addr  in  ADDR_W  VDP fetch address, valid with vid_req
- vid_data  out  PLANES*DW  all planes; plane 0 in [7:0], plane 5 in [47:40]
- vid_valid  out  1  one-cycle pulse, vid_data valid
- cpu_req  in  1  CPU request level; held with addr/we/din/bank stable until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU word address (Z80 address minus EC00 decode offset, done upstream)
- cpu_din  in  DW  write data
- cpu_rd_bank  in  8  F1 register value; 1..6 selects plane 0..5, other values select none
- cpu_wr_bank  in  8  F2 register value; bit i = 1 writes plane i; bits 7:6 ignored
- cpu_dout  out  DW  read data, valid with cpu_ack
- cpu_ack  out  1  one-cycle completion pulse
- cpu_wait_n  out  1  combinational: low while cpu_req = 1 and no ack issued for the current request
- clr_start  in  1  pulse: start fill of all addresses
- clr_mask  in  PLANES  planes written by fill, latched at start
- clr_value  in  DW  fill byte, latched at start
- clr_busy  out  1  fill in progress
- clr_done  out  1  one-cycle pulse after the last fill write is issued
- mem_ce  out  PLANES  per-plane enable, registered
- mem_we  out  1  write strobe, registered
- mem_addr  out  ADDR_W  registered
- mem_din  out  DW  registered, common to all planes
- mem_q  in  PLANES*DW  synchronous RAM read data, valid one cycle after ce

Behaviour:
- Reset (async): all registered outputs 0; pipeline cleared; fill idle; in-flight CPU request dropped with no ack. cpu_wait_n follows cpu_req.
- One memory op is issued per clock. Arbitration at each edge E0:
  - vid_req wins.
  - Otherwise a CPU request is issued if cpu_req = 1 and no CPU op is in flight or being acked.
  - Otherwise a fill write is issued if clr_busy.
- Issued op drives mem_* during the cycle after E0. The RAM samples at E1. mem_q is captured at E2.
- Video read: mem_ce = all ones, mem_we = 0. vid_valid and vid_data are high in the cycle after E2, giving a fixed latency of 2 clocks from the vid_req cycle to vid_valid. Latency is never stretched.
- CPU write: mem_ce = cpu_wr_bank[5:0], mem_we = 1. If the mask is 0 there is no RAM access, but an ack is still given.
- CPU read: mem_ce = one-hot plane from cpu_rd_bank, mem_we = 0. cpu_dout = selected plane byte; 0x00 when rd_bank is not 1..6.
- cpu_ack: two clocks after issue, for both reads and writes. cpu_req in the ack cycle is not a new request; the next request can issue at the following edge.
- A CPU request deferred by video is retried every cycle and has no timeout.
- Fill engine:
  - clr_start while idle: latch mask/value, address counter = 0, clr_busy = 1 from the next cycle.
  - Each issued fill write increments the counter.
  - Issuing address 8191: clr_busy drops and clr_done pulses in the same cycle. The counter does not wrap.
  - clr_start while busy is ignored. clr_mask = 0 still sweeps all addresses with no writes.
- Fill and CPU writes to the same address are serialized by issue order; the later-issued write wins.

Test Plan:
- Video latency: vid_req with vid_addr=0x0010, plane 3 preloaded with 0xA5 -> vid_valid exactly 2 clocks later, vid_data[31:24]=0xA5.
- CPU write then read: wr_bank=0x05, write 0x3C to 0x1234; then rd_bank=3 read 0x1234 -> ack after 2 clocks each, cpu_dout=0x3C; rd_bank=2 read -> 0x00.
- Priority: vid_req every cycle for 10 cycles with cpu_req held -> CPU issues only after video stops; every vid_valid has latency 2; cpu_wait_n low throughout.
- Fill: clr_start with mask=0x3F, value=0xFF, no other traffic -> clr_busy for 8192 cycles, clr_done once, every address reads 0xFF on all planes; second clr_start mid-fill is ignored.
- Interleave: fill running while the CPU writes 0x11 to 0x0000 after the fill passes it -> location reads 0x11; fill still completes with 8192 issued writes.
- Reset mid-op: assert reset_n=0 one cycle after a CPU read issue -> no cpu_ack, all outputs 0, clr_busy=0; normal operation after release.
